// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared FSM state encoding for the interrupt controller
package int_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_ACK  = 2'b10;
  localparam logic [1:0] ST_SERV = 2'b11;

endpackage

// File: rtl/int_ctrl_if.sv
// rtl/int_ctrl_if.sv - request/mask/handshake bundle between CPU sequencer and int_ctrl
interface int_ctrl_if #(
  parameter int N  = 4,
  parameter int VW = 2
);

  logic [N-1:0]  irq;
  logic [N-1:0]  mask_in;
  logic          mask_ld;
  logic          int_ack;
  logic          eoi;
  logic          int_req;
  logic [VW-1:0] vec;
  logic          vec_valid;
  logic [N-1:0]  pending;
  logic [N-1:0]  in_service;
  logic          busy;

  modport master (
    output irq, mask_in, mask_ld, int_ack, eoi,
    input  int_req, vec, vec_valid, pending, in_service, busy
  );

  modport slave (
    input  irq, mask_in, mask_ld, int_ack, eoi,
    output int_req, vec, vec_valid, pending, in_service, busy
  );

endinterface

// File: rtl/int_ctrl_prio_enc.sv
// rtl/int_ctrl_prio_enc.sv - combinational lowest-index-first priority encoder
module prio_enc #(
  parameter int N  = 4,
  parameter int VW = 2
) (
  input  logic [N-1:0]  req,
  output logic [VW-1:0] idx,
  output logic          any
);

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = VW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ld_st_reg.sv
// rtl/ld_st_reg.sv - loadable register with synchronous active-low clear
module ld_st_reg #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic [n-1:0] d,
  output logic [n-1:0] q
);

  always_ff @(posedge clk) begin
    if (!clr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - priority interrupt controller with edge capture, mask and req/ack/eoi handshake
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int N  = 4,
  parameter int VW = 2
) (
  input  logic     clk,
  input  logic     clr,
  int_ctrl_if.slave bus
);

  if (N > (1 << VW)) begin : g_width_check
    $error("int_ctrl: N exceeds 2**VW");
  end

  logic [1:0]    state;
  logic [N-1:0]  irq_prev;
  logic [N-1:0]  mask_q;
  logic [N-1:0]  pend_q;
  logic [N-1:0]  insv_q;
  logic [N-1:0]  cand;
  logic [N-1:0]  win_oh;
  logic [VW-1:0] win_idx;
  logic [VW-1:0] vec_q;
  logic          sel_any;
  logic          take;

  ld_st_reg #(.n(N)) u_mask (
    .clk (clk),
    .clr (clr),
    .ld  (bus.mask_ld),
    .d   (bus.mask_in),
    .q   (mask_q)
  );

  assign cand = pend_q & mask_q;

  prio_enc #(.N(N), .VW(VW)) u_enc (
    .req (cand),
    .idx (win_idx),
    .any (sel_any)
  );

  assign take   = (state == ST_REQ) && bus.int_ack && sel_any;
  assign win_oh = take ? (N'(1) << win_idx) : '0;

  // The edge-set term is OR'd after the ack clear so a re-edge on the
  // winning line at the ack edge leaves it pending.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= ST_IDLE;
      irq_prev <= '0;
      pend_q   <= '0;
      insv_q   <= '0;
      vec_q    <= '0;
    end else begin
      irq_prev <= bus.irq;
      pend_q   <= (pend_q & ~win_oh) | (bus.irq & ~irq_prev);
      case (state)
        ST_IDLE: begin
          if (sel_any) state <= ST_REQ;
        end
        ST_REQ: begin
          if (take) begin
            state  <= ST_ACK;
            vec_q  <= win_idx;
            insv_q <= win_oh;
          end else if (!sel_any) begin
            state <= ST_IDLE;
          end
        end
        ST_ACK: begin
          state <= ST_SERV;
        end
        default: begin
          if (bus.eoi) begin
            insv_q <= '0;
            state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.int_req    = (state == ST_REQ);
  assign bus.vec_valid  = (state == ST_ACK);
  assign bus.busy       = (state == ST_ACK) || (state == ST_SERV);
  assign bus.vec        = vec_q;
  assign bus.pending    = pend_q;
  assign bus.in_service = insv_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed table-driven bench for int_ctrl
module tb_int_ctrl;

  logic clk;
  logic clr;

  int_ctrl_if #(.N(4), .VW(2)) bus_if ();

  int_ctrl #(.N(4), .VW(2)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        clr;
    logic [3:0]  irq;
    logic        ld;
    logic [3:0]  mask;
    logic        ack;
    logic        eoi;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t row(string nm, logic c, logic [3:0] i, logic l, logic [3:0] m,
                               logic a, logic e, logic rq, logic [1:0] v, logic vv,
                               logic [3:0] p, logic [3:0] s, logic b);
    vec_t r;
    r.name = nm; r.clr = c; r.irq = i; r.ld = l; r.mask = m; r.ack = a; r.eoi = e;
    r.exp  = {rq, v, vv, p, s, b};
    return r;
  endfunction

  function automatic logic [12:0] outs();
    return {bus_if.int_req, bus_if.vec, bus_if.vec_valid, bus_if.pending,
            bus_if.in_service, bus_if.busy};
  endfunction

  task automatic apply(input logic c, input logic [3:0] i, input logic l, input logic [3:0] m,
                       input logic a, input logic e);
    clr            = c;
    bus_if.irq     = i;
    bus_if.mask_ld = l;
    bus_if.mask_in = m;
    bus_if.int_ack = a;
    bus_if.eoi     = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", nm, got, exp);
    end
  endtask

  initial begin
    // outputs packed as {int_req, vec[1:0], vec_valid, pending, in_service, busy}
    tbl.push_back(row("rst_hold0",  0, 4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(row("rst_hold1",  0, 4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(row("release",    1, 4'b1111, 1, 4'b1111, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0));
    tbl.push_back(row("req_after2", 1, 4'b1111, 0, 4'b0000, 0, 0, 1, 0, 0, 4'b1111, 4'b0000, 0));
    tbl.push_back(row("ack0",       1, 4'b1111, 0, 4'b0000, 1, 0, 0, 0, 1, 4'b1110, 4'b0001, 1));
    tbl.push_back(row("serv0",      1, 4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b1110, 4'b0001, 1));
    tbl.push_back(row("eoi0",       1, 4'b1111, 0, 4'b0000, 0, 1, 0, 0, 0, 4'b1110, 4'b0000, 0));
    tbl.push_back(row("rst_again",  0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(row("release2",   1, 4'b0000, 1, 4'b1111, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(row("irq2_edge",  1, 4'b0100, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0100, 4'b0000, 0));
    tbl.push_back(row("req2",       1, 4'b0000, 0, 4'b0000, 0, 0, 1, 0, 0, 4'b0100, 4'b0000, 0));
    tbl.push_back(row("ack2",       1, 4'b0000, 0, 4'b0000, 1, 0, 0, 2, 1, 4'b0000, 4'b0100, 1));
    tbl.push_back(row("serv2",      1, 4'b0000, 0, 4'b0000, 0, 0, 0, 2, 0, 4'b0000, 4'b0100, 1));
    tbl.push_back(row("ack_in_serv",1, 4'b0000, 0, 4'b0000, 1, 0, 0, 2, 0, 4'b0000, 4'b0100, 1));
    tbl.push_back(row("eoi2",       1, 4'b0000, 0, 4'b0000, 0, 1, 0, 2, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(row("idle_ignore",1, 4'b0000, 0, 4'b0000, 1, 1, 0, 2, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(row("irq3_edge",  1, 4'b1000, 0, 4'b0000, 0, 0, 0, 2, 0, 4'b1000, 4'b0000, 0));
    tbl.push_back(row("req3",       1, 4'b1000, 0, 4'b0000, 0, 0, 1, 2, 0, 4'b1000, 4'b0000, 0));
    tbl.push_back(row("irq1_preempt",1,4'b1010, 0, 4'b0000, 0, 1, 1, 2, 0, 4'b1010, 4'b0000, 0));
    tbl.push_back(row("ack1",       1, 4'b1010, 0, 4'b0000, 1, 0, 0, 1, 1, 4'b1000, 4'b0010, 1));
    tbl.push_back(row("serv1",      1, 4'b1010, 0, 4'b0000, 0, 0, 0, 1, 0, 4'b1000, 4'b0010, 1));
    tbl.push_back(row("eoi1",       1, 4'b1010, 0, 4'b0000, 0, 1, 0, 1, 0, 4'b1000, 4'b0000, 0));
    tbl.push_back(row("b2b_req3",   1, 4'b1010, 0, 4'b0000, 0, 0, 1, 1, 0, 4'b1000, 4'b0000, 0));
    tbl.push_back(row("ack3",       1, 4'b1010, 0, 4'b0000, 1, 0, 0, 3, 1, 4'b0000, 4'b1000, 1));
    tbl.push_back(row("serv3",      1, 4'b1010, 0, 4'b0000, 0, 0, 0, 3, 0, 4'b0000, 4'b1000, 1));
    tbl.push_back(row("eoi3",       1, 4'b1010, 0, 4'b0000, 0, 1, 0, 3, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(row("quiet",      1, 4'b0000, 0, 4'b0000, 0, 0, 0, 3, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(row("mask_none",  1, 4'b0000, 1, 4'b0000, 0, 0, 0, 3, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(row("irq0_masked",1, 4'b0001, 0, 4'b0000, 0, 0, 0, 3, 0, 4'b0001, 4'b0000, 0));
    tbl.push_back(row("masked_hold",1, 4'b0001, 0, 4'b0000, 0, 0, 0, 3, 0, 4'b0001, 4'b0000, 0));
    tbl.push_back(row("mask_ld1",   1, 4'b0001, 1, 4'b0001, 0, 0, 0, 3, 0, 4'b0001, 4'b0000, 0));
    tbl.push_back(row("mask_req",   1, 4'b0001, 0, 4'b0000, 0, 0, 1, 3, 0, 4'b0001, 4'b0000, 0));
    tbl.push_back(row("mask_clr",   1, 4'b0001, 1, 4'b0000, 0, 0, 1, 3, 0, 4'b0001, 4'b0000, 0));
    tbl.push_back(row("ack_nosel",  1, 4'b0001, 0, 4'b0000, 1, 0, 0, 3, 0, 4'b0001, 4'b0000, 0));
    tbl.push_back(row("ack_idle",   1, 4'b0001, 0, 4'b0000, 1, 0, 0, 3, 0, 4'b0001, 4'b0000, 0));

    clr = 1'b0;
    bus_if.irq = '0; bus_if.mask_in = '0; bus_if.mask_ld = 1'b0;
    bus_if.int_ack = 1'b0; bus_if.eoi = 1'b0;

    foreach (tbl[k]) begin
      apply(tbl[k].clr, tbl[k].irq, tbl[k].ld, tbl[k].mask, tbl[k].ack, tbl[k].eoi);
      chk(tbl[k].name, outs(), tbl[k].exp);
    end

    // Re-edge on the line being acknowledged keeps it pending.
    apply(0, 4'b0000, 0, 4'b0000, 0, 0);
    apply(1, 4'b0000, 1, 4'b1111, 0, 0);
    apply(1, 4'b0100, 0, 4'b0000, 0, 0);
    apply(1, 4'b0000, 0, 4'b0000, 0, 0);
    chk("reedge_req", 13'(bus_if.int_req), 13'd1);
    apply(1, 4'b0100, 0, 4'b0000, 1, 0);
    chk("reedge_pending", 13'(bus_if.pending), 13'b0100);
    chk("reedge_insv", 13'(bus_if.in_service), 13'b0100);
    chk("reedge_vv", 13'(bus_if.vec_valid), 13'd1);

    // Reset in the middle of servicing line 1.
    apply(0, 4'b0000, 0, 4'b0000, 0, 0);
    apply(1, 4'b0000, 1, 4'b1111, 0, 0);
    apply(1, 4'b0010, 0, 4'b0000, 0, 0);
    apply(1, 4'b0010, 0, 4'b0000, 0, 0);
    apply(1, 4'b0010, 0, 4'b0000, 1, 0);
    apply(1, 4'b0010, 0, 4'b0000, 0, 0);
    chk("serv_insv", 13'(bus_if.in_service), 13'b0010);
    chk("serv_busy", 13'(bus_if.busy), 13'd1);
    apply(0, 4'b1111, 0, 4'b0000, 1, 0);
    chk("midserv_rst", outs(), 13'd0);
    apply(1, 4'b1111, 0, 4'b0000, 0, 0);
    chk("post_rst_pending", 13'(bus_if.pending), 13'b1111);
    chk("post_rst_idle", {12'd0, bus_if.int_req | bus_if.busy}, 13'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
